// File: rtl/text_pkg.sv
// Shared constants and arbiter state encoding for the text line scheduler.
// Imported by rr_arbiter2 and text_slot_scheduler.
package text_pkg;
  localparam int SLOT_W = 8;
  localparam int SLOT_H = 16;
  localparam int ASCII_W = 7;
  localparam logic [ASCII_W-1:0] ASCII_SPACE = 7'h20;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with an IDLE/GRANT handshake FSM.
// gnt is a registered one-cycle pulse; sel names the granted requester.
module rr_arbiter2
  import text_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       sel
);
  arb_state_t state;
  logic ptr;
  logic pick;

  // Contention follows the pointer; a lone request wins outright.
  always_comb pick = (req == 2'b11) ? ptr : req[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      ptr   <= 1'b0;
      gnt   <= 2'b00;
      sel   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (|req) begin
            state <= ST_GRANT;
            sel   <= pick;
            gnt   <= pick ? 2'b10 : 2'b01;
            ptr   <= ~pick;
          end
        end
        ST_GRANT: begin
          state <= ST_IDLE;
          gnt   <= 2'b00;
        end
      endcase
    end
  end
endmodule

// File: rtl/text_slot_scheduler.sv
// Text line owner: arbitrated writes, per-frame commit, pixel pipeline.
// Optional cursor blink when CURSOR_BLINK_EN is defined.
module text_slot_scheduler
  import text_pkg::*;
#(
  parameter int CHARS        = 16,
  parameter int X0           = 80,
  parameter int Y0           = 80,
  parameter int V_ACTIVE     = 480,
  parameter int BLINK_FRAMES = 30,
  localparam int IDXW        = $clog2(CHARS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [9:0]      x,
  input  logic [9:0]      y,
  input  logic [1:0]      req,
  input  logic [IDXW-1:0] wr_slot0,
  input  logic [IDXW-1:0] wr_slot1,
  input  logic [6:0]      wr_char0,
  input  logic [6:0]      wr_char1,
  output logic [1:0]      gnt,
  output logic [6:0]      ascii,
  output logic            disp,
  output logic [3:0]      row_d,
  output logic [2:0]      col_d,
  input  logic [IDXW-1:0] cursor_slot,
  output logic            cursor_inv
);
  localparam logic [9:0] X_LO = 10'(X0);
  localparam logic [9:0] X_HI = 10'(X0 + SLOT_W*CHARS - 1);
  localparam logic [9:0] Y_LO = 10'(Y0);
  localparam logic [9:0] Y_HI = 10'(Y0 + SLOT_H - 1);
  localparam logic [9:0] Y_VA = 10'(V_ACTIVE);

  logic [6:0] pending [CHARS];
  logic [6:0] display [CHARS];

  logic            sel;
  logic            wr_en;
  logic [IDXW-1:0] wr_idx;
  logic [6:0]      wr_dat;
  logic            commit;
  logic            in_line;
  logic            in_slot;
  logic [9:0]      off;
  logic [IDXW-1:0] slot;
  logic            unused_off;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt),
    .sel   (sel)
  );

  assign wr_en  = |gnt;
  assign wr_idx = sel ? wr_slot1 : wr_slot0;
  assign wr_dat = sel ? wr_char1 : wr_char0;
  assign commit = (y == Y_VA) && (x == 10'd0);

  assign in_line = (y >= Y_LO) && (y <= Y_HI);
  assign in_slot = (x >= X_LO) && (x <= X_HI);
  // Offset is only meaningful inside the window, so no wrap is seen.
  assign off  = x - X_LO;
  assign slot = off[IDXW+2:3];
  assign unused_off = ^{off[9:IDXW+3], off[2:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHARS; i++) begin
        pending[i] <= ASCII_SPACE;
        display[i] <= ASCII_SPACE;
      end
    end else begin
      if (wr_en) pending[wr_idx] <= wr_dat;
      // Display takes the pre-write snapshot of pending.
      if (commit) begin
        for (int i = 0; i < CHARS; i++) display[i] <= pending[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ascii <= ASCII_SPACE;
      disp  <= 1'b0;
      row_d <= 4'd0;
      col_d <= 3'd0;
    end else begin
      ascii <= in_slot ? display[slot] : ASCII_SPACE;
      disp  <= in_line && in_slot;
      row_d <= y[3:0];
      col_d <= x[2:0];
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  logic [BW-1:0] blink_cnt;
  logic          phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt  <= '0;
      phase      <= 1'b0;
      cursor_inv <= 1'b0;
    end else begin
      if (commit) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
      cursor_inv <= phase && in_line && in_slot && (slot == cursor_slot);
    end
  end
`else
  localparam int unused_blink = BLINK_FRAMES;
  logic unused_cursor;

  assign unused_cursor = ^cursor_slot;
  assign cursor_inv    = 1'b0;
`endif
endmodule

// File: tb/tb_text_slot_scheduler.sv
// Self-checking bench for text_slot_scheduler: directed cases, then random traffic.
// Honours CURSOR_BLINK_EN for the cursor checks.
module tb_text_slot_scheduler;
  localparam int CHARS = 16;
  localparam int TB_BF = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x, y;
  logic [1:0] req;
  logic [3:0] wr_slot0, wr_slot1, cursor_slot;
  logic [6:0] wr_char0, wr_char1;
  logic [1:0] gnt;
  logic [6:0] ascii;
  logic       disp;
  logic [3:0] row_d;
  logic [2:0] col_d;
  logic       cursor_inv;

  always #5 clk = ~clk;

  text_slot_scheduler #(.BLINK_FRAMES(TB_BF)) dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .y           (y),
    .req         (req),
    .wr_slot0    (wr_slot0),
    .wr_slot1    (wr_slot1),
    .wr_char0    (wr_char0),
    .wr_char1    (wr_char1),
    .gnt         (gnt),
    .ascii       (ascii),
    .disp        (disp),
    .row_d       (row_d),
    .col_d       (col_d),
    .cursor_slot (cursor_slot),
    .cursor_inv  (cursor_inv)
  );

  // Reference model state
  logic [6:0] m_pend [CHARS];
  logic [6:0] m_disp [CHARS];
  int         m_ptr;
  int         m_commits;
  logic [1:0] e_gnt;
  logic [6:0] e_ascii;
  logic       e_disp;
  logic [3:0] e_row;
  logic [2:0] e_col;
  logic       e_inv;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict the state after the coming rising edge from the current inputs.
  task automatic model_step();
    logic       il, is;
    int         s, w;
    logic [6:0] snap [CHARS];
    if (reset) begin
      for (int i = 0; i < CHARS; i++) begin
        m_pend[i] = 7'h20;
        m_disp[i] = 7'h20;
      end
      m_ptr = 0; m_commits = 0;
      e_gnt = 2'b00; e_ascii = 7'h20; e_disp = 1'b0;
      e_row = 4'd0; e_col = 3'd0; e_inv = 1'b0;
      return;
    end
    il = (y >= 80) && (y <= 95);
    is = (x >= 80) && (x < 80 + 8*CHARS);
    s  = is ? (int'(x) - 80) / 8 : 0;
    e_disp  = il && is;
    e_ascii = is ? m_disp[s] : 7'h20;
    e_row   = y[3:0];
    e_col   = x[2:0];
`ifdef CURSOR_BLINK_EN
    e_inv = ((m_commits / TB_BF) % 2 == 1) && e_disp && (s == int'(cursor_slot));
`else
    e_inv = 1'b0;
`endif
    snap = m_pend;
    if (e_gnt[0]) m_pend[wr_slot0] = wr_char0;
    else if (e_gnt[1]) m_pend[wr_slot1] = wr_char1;
    if (y == 10'd480 && x == 10'd0) begin
      m_disp = snap;
      m_commits++;
    end
    if (e_gnt != 2'b00) begin
      e_gnt = 2'b00;
    end else if (req != 2'b00) begin
      w = (req == 2'b11) ? m_ptr : (req[1] ? 1 : 0);
      e_gnt = (w == 1) ? 2'b10 : 2'b01;
      m_ptr = 1 - w;
    end
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("ascii", 32'(ascii), 32'(e_ascii));
    chk("disp", 32'(disp), 32'(e_disp));
    chk("row_d", 32'(row_d), 32'(e_row));
    chk("col_d", 32'(col_d), 32'(e_col));
    chk("cursor_inv", 32'(cursor_inv), 32'(e_inv));
  endtask

  task automatic px(input int px_x, input int px_y);
    x = 10'(px_x); y = 10'(px_y);
    cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 2'b00;
    cycle();
    reset = 1'b0;
  endtask

  task automatic frame_commit();
    px(0, 480);
  endtask

  initial begin
    reset = 1'b1; x = '0; y = '0; req = 2'b00;
    wr_slot0 = '0; wr_slot1 = '0; wr_char0 = 7'h20; wr_char1 = 7'h20;
    cursor_slot = '0;
    cycle();
    cycle();
    chk("reset_ascii", 32'(ascii), 32'h20);
    chk("reset_disp", 32'(disp), 32'd0);
    chk("reset_gnt", 32'(gnt), 32'd0);
    reset = 1'b0;

    // Window edges
    px(79, 80);  chk("x79_disp", 32'(disp), 32'd0);
    px(80, 80);  chk("x80_disp", 32'(disp), 32'd1);
    chk("x80_ascii", 32'(ascii), 32'h20);
    px(207, 95); chk("x207_disp", 32'(disp), 32'd1);
    px(208, 90); chk("x208_disp", 32'(disp), 32'd0);
    px(100, 79); chk("y79_disp", 32'(disp), 32'd0);
    px(100, 96); chk("y96_disp", 32'(disp), 32'd0);

    // Single write, then commit
    x = '0; y = '0;
    req = 2'b01; wr_slot0 = 4'd3; wr_char0 = 7'h46;
    cycle(); chk("t2_gnt", 32'(gnt), 32'b01);
    req = 2'b00;
    cycle(); chk("t2_gnt_off", 32'(gnt), 32'b00);
    px(104, 80); chk("t2_precommit", 32'(ascii), 32'h20);
    frame_commit();
    px(104, 80); chk("t2_x104", 32'(ascii), 32'h46);
    px(111, 80); chk("t2_x111", 32'(ascii), 32'h46);
    px(112, 80); chk("t2_x112", 32'(ascii), 32'h20);

    // Contention on slot 0
    do_reset();
    x = '0; y = '0;
    req = 2'b11; wr_slot0 = 4'd0; wr_char0 = 7'h30;
    wr_slot1 = 4'd0; wr_char1 = 7'h41;
    cycle(); chk("t3_g1", 32'(gnt), 32'b01);
    cycle(); chk("t3_z1", 32'(gnt), 32'b00);
    cycle(); chk("t3_g2", 32'(gnt), 32'b10);
    cycle(); chk("t3_z2", 32'(gnt), 32'b00);
    cycle(); chk("t3_g3", 32'(gnt), 32'b01);
    req = 2'b00;
    cycle();
    frame_commit();
    px(80, 80); chk("t3_final", 32'(ascii), 32'h30);

    // Write landing in the commit cycle
    x = '0; y = '0;
    req = 2'b01; wr_slot0 = 4'd5; wr_char0 = 7'h5a;
    cycle(); chk("t4_gnt", 32'(gnt), 32'b01);
    req = 2'b00;
    frame_commit();
    px(120, 80); chk("t4_same_frame", 32'(ascii), 32'h20);
    frame_commit();
    px(127, 80); chk("t4_next_frame", 32'(ascii), 32'h5a);

    // Reset during GRANT
    x = '0; y = '0;
    req = 2'b01; wr_slot0 = 4'd7; wr_char0 = 7'h55;
    cycle(); chk("t5_gnt", 32'(gnt), 32'b01);
    reset = 1'b1; req = 2'b00;
    cycle(); chk("t5_gnt_after", 32'(gnt), 32'b00);
    reset = 1'b0;
    frame_commit();
    px(136, 80); chk("t5_slot7", 32'(ascii), 32'h20);
    px(120, 80); chk("t5_slot5", 32'(ascii), 32'h20);

`ifdef CURSOR_BLINK_EN
    do_reset();
    cursor_slot = 4'd0;
    for (int f = 0; f < 6; f++) begin
      px(84, 85); chk("t6_inv_slot0", 32'(cursor_inv), (f == 2 || f == 3) ? 32'd1 : 32'd0);
      px(90, 85); chk("t6_inv_slot1", 32'(cursor_inv), 32'd0);
      frame_commit();
    end
`endif

    // Random traffic with well-behaved requesters
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (e_gnt[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && ($urandom_range(0, 2) == 0)) begin
          req[i] = 1'b1;
          if (i == 0) begin
            wr_slot0 = 4'($urandom_range(0, 15));
            wr_char0 = 7'($urandom_range(32, 126));
          end else begin
            wr_slot1 = 4'($urandom_range(0, 15));
            wr_char1 = 7'($urandom_range(32, 126));
          end
        end
      end
      if ($urandom_range(0, 39) == 0) begin
        x = 10'd0; y = 10'd480;
      end else begin
        x = 10'($urandom_range(70, 220));
        y = 10'($urandom_range(74, 100));
      end
      cursor_slot = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 499) == 0);
      if (reset) req = 2'b00;
      cycle();
      reset = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
